// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and a saturating bubble counter.
// Optional HALT_DETECT_EN: an all-zero opcode halts the core until reset.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_ALUSrc,
  input  logic              id_MemtoReg,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_Branch,
  input  logic              id_JaltoReg,
  input  logic [1:0]        id_ALUOp,
  input  logic [6:0]        id_opcode,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic              ex_ALUSrc,
  output logic              ex_MemtoReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic              ex_JaltoReg,
  output logic [1:0]        ex_ALUOp,
  output logic [6:0]        ex_opcode,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              stall,
  output logic              halted,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, BUBBLE = 2'd1, HALTED = 2'd2} state_t;

  state_t     state, state_next;
  logic       hazard, halt_req, in_halt;
  logic       take_id, hold, cnt_inc, load_valid;
  logic [8:0] id_ctrl, ex_ctrl;

  assign id_ctrl = {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite,
                    id_Branch, id_JaltoReg, id_ALUOp};
  assign {ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
          ex_Branch, ex_JaltoReg, ex_ALUOp} = ex_ctrl;

  assign hazard = ex_valid & ex_MemRead & (ex_rd != {RA_W{1'b0}}) & id_valid &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));

`ifdef HALT_DETECT_EN
  assign halt_req = id_valid & (id_opcode == 7'b0000000) & ~ex_flush & ~hazard;
  assign in_halt  = (state == HALTED);
`else
  assign halt_req = 1'b0;
  assign in_halt  = 1'b0;
`endif

  assign halted = in_halt;
  assign stall  = ~reset & (in_halt | (hazard & ~ex_flush));

  always_comb begin
    state_next = state;
    take_id    = 1'b0;
    hold       = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      RUN: begin
        if (ex_flush) begin
          cnt_inc = 1'b1;
        end else if (hazard) begin
          cnt_inc    = 1'b1;
          state_next = BUBBLE;
        end else if (halt_req) begin
          state_next = HALTED;
        end else begin
          take_id = 1'b1;
        end
      end
      BUBBLE: begin
        state_next = RUN;
        if (ex_flush) begin
          cnt_inc = 1'b1;
        end else if (halt_req) begin
          state_next = HALTED;
        end else begin
          take_id = 1'b1;
        end
      end
      HALTED: begin
        hold = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // An invalid ID slot loads as a bubble without being counted.
  assign load_valid = take_id & id_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      ex_valid   <= 1'b0;
      ex_ctrl    <= 9'd0;
      ex_opcode  <= 7'd0;
      ex_pc      <= {PC_W{1'b0}};
      ex_rd1     <= {DATA_W{1'b0}};
      ex_rd2     <= {DATA_W{1'b0}};
      ex_imm     <= {DATA_W{1'b0}};
      ex_rs1     <= {RA_W{1'b0}};
      ex_rs2     <= {RA_W{1'b0}};
      ex_rd      <= {RA_W{1'b0}};
      ex_funct3  <= 3'd0;
      ex_funct7  <= 7'd0;
      bubble_cnt <= {CNT_W{1'b0}};
    end else begin
      state <= state_next;
      if (!hold) begin
        ex_valid  <= load_valid;
        ex_ctrl   <= load_valid ? id_ctrl : 9'd0;
        ex_opcode <= id_opcode;
        ex_pc     <= id_pc;
        ex_rd1    <= id_rd1;
        ex_rd2    <= id_rd2;
        ex_imm    <= id_imm;
        ex_rs1    <= id_rs1;
        ex_rs2    <= id_rs2;
        ex_rd     <= id_rd;
        ex_funct3 <= id_funct3;
        ex_funct7 <= id_funct7;
      end
      if (cnt_inc && (bubble_cnt != {CNT_W{1'b1}})) begin
        bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
